// File: rtl/ps2_keyevent_ci.sv
// ps2_keyevent_ci: Nios II multi-cycle custom instruction that receives PS/2 keyboard
// frames from the raw pins, decodes E0/F0 prefixes into key events and queues them.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   clk_en, start    custom-instruction enable and one-cycle start pulse
//   n[1:0]           opcode: 0=POP, 1=PEEK, 2=STATUS, 3=FLUSH
//   ps2_clk, ps2_dat raw (asynchronous) PS/2 pins
//   done             one-cycle completion pulse, one cycle after acceptance
//   result[31:0]     instruction result, held until the next completion
//   irq              (only with PS2_KEYEVENT_IRQ_EN) high while events are queued or overflow
//
// Optional feature macro: PS2_KEYEVENT_IRQ_EN adds the registered irq output.
// Event word: [31]=valid, [9]=ext, [8]=brk, [7:0]=code.
// STATUS word: [31]=overflow, [23:16]=error count, [15:8]=fill count, [0]=not empty.

module ps2_keyevent_ci #(
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned WATCHDOG_CYCLES = 50000,
    parameter int unsigned ERR_W           = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        done,
    output logic [31:0] result
`ifdef PS2_KEYEVENT_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    // Synchronisers and edge detection
    logic clk_meta_q, clk_sync_q, clk_prev_q, dat_meta_q, dat_sync_q;
    logic fall;

    // Receiver
    rx_state_e st_q, st_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          frame_good, frame_err, wd_abort;
    logic          byte_vld_q;
    logic [7:0]    byte_q;

    // Decode, FIFO and instruction state
    logic             ext_q, ext_d, brk_q, brk_d;
    logic             ovf_q, ovf_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      result_d;
    logic             accept, op_pop, op_peek, op_status, op_flush;
    logic             not_empty, full, is_prefix, ev_push, do_push, do_pop, ovf_set, err_inc;
    logic [7:0]       err8, fill8;

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        st_d       = st_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        wd_d       = '0;
        frame_good = 1'b0;
        frame_err  = 1'b0;
        wd_abort   = 1'b0;
        if (st_q != StIdle) wd_d = wd_q + WW'(1);
        if (fall) begin
            wd_d = '0;
            unique case (st_q)
                StIdle: begin
                    if (!dat_sync_q) begin
                        st_d      = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shreg_d   = {dat_sync_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) st_d = StParity;
                end
                StParity: begin
                    par_d = dat_sync_q;
                    st_d  = StStop;
                end
                StStop: begin
                    // Good frame: odd parity over data+parity and stop bit high
                    if ((^{shreg_q, par_q}) && dat_sync_q) frame_good = 1'b1;
                    else                                   frame_err  = 1'b1;
                    st_d = StIdle;
                end
            endcase
        end else if (st_q != StIdle && wd_q == WW'(WATCHDOG_CYCLES - 1)) begin
            st_d     = StIdle;
            wd_d     = '0;
            wd_abort = 1'b1;
        end
    end

    generate
        if (ERR_W >= 8) begin : g_err_trunc
            assign err8 = err_q[7:0];
        end else begin : g_err_ext
            assign err8 = {{(8 - ERR_W){1'b0}}, err_q};
        end
    endgenerate

    assign fill8 = 8'(count_q);

    always_comb begin
        accept    = start & clk_en;
        op_pop    = accept && (n == 2'd0);
        op_peek   = accept && (n == 2'd1);
        op_status = accept && (n == 2'd2);
        op_flush  = accept && (n == 2'd3);
        not_empty = (count_q != '0);
        full      = (count_q == CW'(FIFO_DEPTH));
        is_prefix = (byte_q == 8'hE0) || (byte_q == 8'hF0);
        ev_push   = byte_vld_q && !is_prefix && !op_flush;
        do_pop    = op_pop && not_empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        do_push   = ev_push && (!full || do_pop);
        ovf_set   = ev_push && full && !do_pop;
        err_inc   = frame_err | wd_abort;

        ext_d = ext_q;
        brk_d = brk_q;
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (err_inc || op_flush) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        // Read-to-clear, but a coinciding event survives the clear
        if (op_flush)       ovf_d = 1'b0;
        else if (op_status) ovf_d = ovf_set;
        else                ovf_d = ovf_q | ovf_set;

        if (op_status)                                 err_d = ERR_W'(err_inc);
        else if (err_inc && err_q != {ERR_W{1'b1}})    err_d = err_q + ERR_W'(1);
        else                                           err_d = err_q;

        if (op_flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            wr_d    = wr_q + PW'(do_push);
            rd_d    = rd_q + PW'(do_pop);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end

        result_d = result;
        if (op_pop || op_peek) result_d = not_empty ? {1'b1, 21'b0, mem[rd_q]} : 32'h0;
        if (op_status)         result_d = {ovf_q, 7'b0, err8, fill8, 7'b0, not_empty};
        if (op_flush)          result_d = 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            st_q       <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
            st_q       <= st_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            wd_q       <= wd_d;
            byte_vld_q <= frame_good;
            if (frame_good) byte_q <= shreg_q;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            done       <= accept;
            result     <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= {ext_q, brk_q, byte_q};
    end

`ifdef PS2_KEYEVENT_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= not_empty | ovf_q;
    end
`endif

endmodule
